// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, instruction fields and datapath select codes for the
// multi-cycle controller (MC_CTRL_STALL_EN adds memory-ready stalling in mc_ctrl).
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DCD = 3'd1, S_EXE = 3'd2, S_MA = 3'd3, S_MR = 3'd4, S_MW = 3'd5, S_WB = 3'd6
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;
  localparam logic [1:0] EXT_OP_ZERO = 2'd0, EXT_OP_SIGN = 2'd1, EXT_OP_LUI = 2'd2;
  localparam logic [2:0] ALU_OP_ADD = 3'd0, ALU_OP_SUB = 3'd1, ALU_OP_OR = 3'd2;
  localparam logic [1:0] NPC_OP_PC4 = 2'd0, NPC_OP_BRANCH = 2'd1, NPC_OP_JUMP = 2'd2, NPC_OP_REG = 2'd3;
  localparam logic [1:0] WRSEL_RT = 2'd0, WRSEL_RD = 2'd1, WRSEL_R31 = 2'd2;
  localparam logic [1:0] WDSEL_ALU = 2'd0, WDSEL_MEM = 2'd1, WDSEL_PC4 = 2'd2;
  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
  } instr_t;
  function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? (fn == FN_ADDU ? I_ADDU : fn == FN_SUBU ? I_SUBU : fn == FN_JR ? I_JR : I_BAD) :
           op == OP_J ? I_J : op == OP_JAL ? I_JAL : op == OP_BEQ ? I_BEQ : op == OP_ORI ? I_ORI :
           op == OP_LUI ? I_LUI : op == OP_LW ? I_LW : op == OP_SW ? I_SW : I_BAD;
  endfunction
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: next-state and control decode from state and instruction fields;
// with MC_CTRL_STALL_EN, MR/MW wait for mem_ready.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MC_CTRL_STALL_EN
  input  logic       mem_ready,
`endif
  output state_t     nxt,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       rf_wr,
  output logic       dm_wr,
  output logic       illegal,
  output logic [1:0] ext_op,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] npc_op,
  output logic [1:0] wr_sel,
  output logic [1:0] wd_sel
);
  instr_t ins;
  logic   mem_done;
`ifdef MC_CTRL_STALL_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif
  assign ins = decode(opcode, funct);
  // Selects depend only on the instruction, so they stay stable across all its states.
  assign ext_op    = ins == I_ORI ? EXT_OP_ZERO : ins == I_LUI ? EXT_OP_LUI : EXT_OP_SIGN;
  assign alu_op    = (ins == I_SUBU || ins == I_BEQ) ? ALU_OP_SUB :
                     (ins == I_ORI || ins == I_LUI) ? ALU_OP_OR : ALU_OP_ADD;
  assign alu_src_b = ins inside {I_ORI, I_LUI, I_LW, I_SW};
  assign wr_sel    = ins == I_JAL ? WRSEL_R31 : (ins == I_ADDU || ins == I_SUBU) ? WRSEL_RD : WRSEL_RT;
  assign wd_sel    = ins == I_JAL ? WDSEL_PC4 : ins == I_LW ? WDSEL_MEM : WDSEL_ALU;
  always_comb begin
    nxt = S_FETCH;
    pc_wr = 1'b0;
    ir_wr = 1'b0;
    rf_wr = 1'b0;
    dm_wr = 1'b0;
    illegal = 1'b0;
    npc_op = NPC_OP_PC4;
    case (state)
      S_FETCH: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
        nxt = S_DCD;
      end
      S_DCD: begin
        pc_wr = ins inside {I_J, I_JAL, I_JR};
        rf_wr = ins == I_JAL;
        illegal = ins == I_BAD;
        npc_op = ins == I_JR ? NPC_OP_REG : NPC_OP_JUMP;
        nxt = ins inside {I_LW, I_SW} ? S_MA :
              ins inside {I_ADDU, I_SUBU, I_ORI, I_LUI, I_BEQ} ? S_EXE : S_FETCH;
      end
      S_EXE: begin
        pc_wr = ins == I_BEQ && zero;
        npc_op = NPC_OP_BRANCH;
        nxt = ins == I_BEQ ? S_FETCH : S_WB;
      end
      S_MA: nxt = ins == I_LW ? S_MR : S_MW;
      S_MR: nxt = mem_done ? S_WB : S_MR;
      S_MW: begin
        dm_wr = 1'b1;
        nxt = mem_done ? S_FETCH : S_MW;
      end
      S_WB: rf_wr = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset Moore controller; define MC_CTRL_STALL_EN to add
// the mem_ready input that stretches MR/MW until data memory completes.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MC_CTRL_STALL_EN
  input  logic       mem_ready,
`endif
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] EXTOp,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] WRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       illegal
);
  state_t state_q, nxt;
  logic   pc_wr, ir_wr, rf_wr, dm_wr, ill;
  mc_ctrl_dec u_dec (
    .state(state_q), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_CTRL_STALL_EN
    .mem_ready(mem_ready),
`endif
    .nxt(nxt), .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr), .illegal(ill),
    .ext_op(EXTOp), .alu_src_b(ALUSrcB), .alu_op(ALUOp), .npc_op(NPCOp), .wr_sel(WRSel), .wd_sel(WDSel)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= nxt;
  // FETCH decodes PCWr/IRWr high, so enables are masked while reset is held.
  assign PCWr    = pc_wr & rst_n;
  assign IRWr    = ir_wr & rst_n;
  assign RFWr    = rf_wr & rst_n;
  assign DMWr    = dm_wr & rst_n;
  assign illegal = ill & rst_n;
  assign state   = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream checked cycle by cycle against a
// path-based model of the controller; directed cases for reset, stalls and illegal ops.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;
  typedef enum {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_BAD} cls_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic PCWr, IRWr, RFWr, DMWr, ALUSrcB, illegal;
  logic [1:0] EXTOp, NPCOp, WRSel, WDSel;
  logic [2:0] ALUOp, state;
  int n_chk = 0, n_err = 0;
`ifdef MC_CTRL_STALL_EN
  logic mem_ready = 1'b1;
`endif
  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MC_CTRL_STALL_EN
    .mem_ready(mem_ready),
`endif
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .EXTOp(EXTOp), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .WRSel(WRSel), .WDSel(WDSel), .state(state), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn == 6'h21 ? C_ADDU : fn == 6'h23 ? C_SUBU : fn == 6'h08 ? C_JR : C_BAD;
    case (op)
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h04: return C_BEQ;
      6'h0d: return C_ORI;
      6'h0f: return C_LUI;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      default: return C_BAD;
    endcase
  endfunction
  // Expected state walk is taken from the instruction's latency table; stall
  // adds extra cycles in MR/MW (only meaningful with mem_ready present).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int stall);
    cls_t c = classify(op, fn);
    int path[$];
    path = {0, 1};
    if (c == C_BEQ) path.push_back(2);
    if (c inside {C_ADDU, C_SUBU, C_ORI, C_LUI}) path = {path, 2, 6};
    if (c == C_SW) begin path.push_back(3); repeat (stall + 1) path.push_back(5); end
    if (c == C_LW) begin path.push_back(3); repeat (stall + 1) path.push_back(4); path.push_back(6); end
    opcode = op; funct = fn; zero = z;
    for (int k = 0; k < path.size(); k++) begin
      int s = path[k];
      logic pcw, rfw;
`ifdef MC_CTRL_STALL_EN
      mem_ready = (s == 4 || s == 5) ? (k + 1 >= path.size() || path[k+1] != s) : 1'($urandom);
`endif
      pcw = s == 0 || (s == 1 && c inside {C_J, C_JAL, C_JR}) || (s == 2 && c == C_BEQ && z);
      rfw = s == 6 || (s == 1 && c == C_JAL);
      @(negedge clk);
      check("state", 32'(state), 32'(s));
      check("PCWr", 32'(PCWr), 32'(pcw));
      check("IRWr", 32'(IRWr), 32'(s == 0));
      check("RFWr", 32'(RFWr), 32'(rfw));
      check("DMWr", 32'(DMWr), 32'(s == 5));
      check("illegal", 32'(illegal), 32'(s == 1 && c == C_BAD));
      if (pcw)
        check("NPCOp", 32'(NPCOp), 32'(s == 0 ? NPC_OP_PC4 : c == C_JR ? NPC_OP_REG :
                                       c == C_BEQ ? NPC_OP_BRANCH : NPC_OP_JUMP));
      if (rfw) begin
        check("WRSel", 32'(WRSel), 32'(c == C_JAL ? WRSEL_R31 : c inside {C_ADDU, C_SUBU} ? WRSEL_RD : WRSEL_RT));
        check("WDSel", 32'(WDSel), 32'(c == C_JAL ? WDSEL_PC4 : c == C_LW ? WDSEL_MEM : WDSEL_ALU));
      end
      if (s != 0 && c inside {C_ORI, C_LUI, C_LW, C_SW, C_BEQ})
        check("EXTOp", 32'(EXTOp), 32'(c == C_ORI ? EXT_OP_ZERO : c == C_LUI ? EXT_OP_LUI : EXT_OP_SIGN));
      if (s == 3) begin
        check("ALUOp_ma", 32'(ALUOp), 32'(ALU_OP_ADD));
        check("ALUSrcB_ma", 32'(ALUSrcB), 32'd1);
      end
      if (s == 2) begin
        check("ALUSrcB_exe", 32'(ALUSrcB), 32'(c inside {C_ORI, C_LUI}));
        if (c != C_ORI && c != C_LUI)
          check("ALUOp_exe", 32'(ALUOp), 32'(c == C_ADDU ? ALU_OP_ADD : ALU_OP_SUB));
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    logic [5:0] fns [3] = '{6'h21, 6'h23, 6'h08};
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_PCWr", 32'(PCWr), 32'd0);
    check("rst_IRWr", 32'(IRWr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(6'h0d, 6'h00, 1'b0, 0);
    run_instr(6'h0f, 6'h15, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
`ifdef MC_CTRL_STALL_EN
    run_instr(6'h2b, 6'h00, 1'b0, 3);
    run_instr(6'h23, 6'h00, 1'b0, 2);
`else
    run_instr(6'h2b, 6'h00, 1'b0, 0);
`endif
    run_instr(6'h3f, 6'h00, 1'b0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0);
    run_instr(6'h00, 6'h21, 1'b0, 0);
    run_instr(6'h00, 6'h23, 1'b0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0);
    run_instr(6'h00, 6'h2a, 1'b0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0);
    // Abort a lw while it sits in MR.
    opcode = 6'h23; funct = 6'h00;
`ifdef MC_CTRL_STALL_EN
    mem_ready = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_MR", 32'(state), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_RFWr", 32'(RFWr), 32'd0);
    check("async_rst_DMWr", 32'(DMWr), 32'd0);
    check("async_rst_PCWr", 32'(PCWr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef MC_CTRL_STALL_EN
    mem_ready = 1'b1;
`endif
    run_instr(6'h23, 6'h00, 1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      logic [5:0] op, fn;
      op = 6'($urandom);
      fn = 6'($urandom);
      if (r < 7) begin
        op = ops[$urandom_range(0, 7)];
        if (op == 6'h00 && r < 6) fn = fns[$urandom_range(0, 2)];
      end
`ifdef MC_CTRL_STALL_EN
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3));
`else
      run_instr(op, fn, 1'($urandom), 0);
`endif
    end
    @(negedge clk);
    check("final_state", 32'(state), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock, rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports opcode  input  6  and funct  input  6: instruction fields taken from the instruction register.
REQ-004 SHALL have port zero  input  1  ALU equality flag.
REQ-005 SHALL have port mem_ready  input  1  data-memory completion, present only with MC_CTRL_STALL_EN.
REQ-006 SHALL have outputs PCWr, IRWr, RFWr, DMWr  1 each: write enables.
REQ-007 SHALL have output EXTOp  2: `EXT_OP_ZERO / `EXT_OP_SIGN / `EXT_OP_LUI select for the immediate extender.
REQ-008 SHALL have outputs ALUSrcB 1, ALUOp 3, NPCOp 2, WRSel 2, WDSel 2: datapath mux and op selects.
REQ-009 SHALL have outputs state 3 (debug) and illegal 1 (undecodable-instruction pulse).

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DCD=1, EXE=2, MA=3, MR=4, MW=5, WB=6, with one registered state and combinational outputs decoded from state, opcode and funct.
REQ-011 SHALL decode addu, subu, jr (R-type via funct), ori, lui, lw, sw, beq, j and jal.
REQ-012 FETCH: PCWr=1, IRWr=1, NPCOp=PC+4; next state DCD.
REQ-013 DCD: j/jal -> FETCH with PCWr=1 and NPCOp=jump. jal also RFWr=1, WRSel=$31, WDSel=PC+4. jr -> FETCH with PCWr=1 and NPCOp=reg. lw/sw -> MA. beq/R-type/ori/lui -> EXE. Any other opcode or funct -> FETCH with illegal=1 for one cycle and all write enables 0.
REQ-014 EXTOp: ori=ZERO; lw/sw/beq=SIGN; lui=LUI. EXTOp SHALL be held stable in every non-FETCH state of the instruction.
REQ-015 EXE: beq -> FETCH, PCWr=zero, NPCOp=branch, ALUOp=sub. All other instructions -> WB.
REQ-016 MA: lw -> MR; sw -> MW; ALUOp=add, ALUSrcB=imm.
REQ-017 MR -> WB. MW -> FETCH with DMWr=1.
REQ-018 WB -> FETCH with RFWr=1. WRSel=rd for R-type, rt otherwise. WDSel=mem for lw, ALU otherwise.
REQ-019 Latencies in cycles, FETCH to next FETCH: j/jal/jr 2, beq 3, R-type/ori/lui 4, sw 4, lw 5 (without stalls).
REQ-020 Write enables SHALL NOT be asserted in any state other than those listed in REQ-012 to REQ-018.

Reset
REQ-021 When rst_n=0, state SHALL become FETCH immediately (asynchronously), and every write enable and illegal SHALL be 0.
REQ-022 Reset asserted mid-instruction SHALL abort that instruction with no partial write. The first rising edge after release SHALL be in FETCH.

Configuration
REQ-023 With MC_CTRL_STALL_EN defined: MR and MW SHALL hold, with DMWr held asserted in MW, until mem_ready=1, then advance. The mem_ready port SHALL exist.
REQ-024 Without MC_CTRL_STALL_EN: MR and MW SHALL last exactly one cycle, and no mem_ready port SHALL exist.

Structure
REQ-025 Shared macro file SHALL hold the state encodings, opcode/funct constants, EXT_OP_*, ALU_OP_*, NPC_OP_*, WRSEL_* and WDSEL_*.
REQ-026 The output decoder MAY be sub-module mc_ctrl_dec (state, opcode, funct, zero -> controls). The FSM register SHALL stay in mc_ctrl.

Verification
REQ-027 Reset check: assert rst_n=0 while in MR, then release. Required: state=0 at once, RFWr=0 and DMWr=0, then PCWr=IRWr=1 on the first cycle.
REQ-028 ori (opcode 0x0D). Required: states 0,1,2,6,0, EXTOp=ZERO in states 1/2/6, RFWr=1 only in state 6, WRSel=rt.
REQ-029 lui (0x0F), then lw (0x23). Required: EXTOp=LUI for lui. For lw: EXTOp=SIGN and states 0,1,3,4,6,0 (5 cycles), WDSel=mem.
REQ-030 beq (0x04) with zero=1, then with zero=0. Required: 3 cycles each, PCWr=1 in EXE only when zero=1.
REQ-031 sw (0x2B) with MC_CTRL_STALL_EN and mem_ready low for 3 cycles. Required: state stays 5 for 4 cycles with DMWr=1 throughout, then returns to 0.
REQ-032 Illegal opcode 0x3F, then jal (0x03). Required: illegal=1 for one cycle and return to 0 with no writes. jal: 2 cycles, RFWr=1 with WRSel=$31, NPCOp=jump.
